jt6295_romarb: RTL and testbench
================================

JT6295_ROMARB -- requirements
Module: jt6295_romarb

Interface
REQ-001 The block SHALL expose parameter AW, default 18, meaning ROM address width.
REQ-002 The block SHALL expose parameter SETTLE, default 1, meaning cycles rom_ok is ignored after an address is issued.
REQ-003 The block SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 The block SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 The block SHALL have ports addr0..addr3, input, AW each: requester byte address.
REQ-006 The block SHALL have ports cs0..cs3, input, 1 each: requester wants addrN.
REQ-007 The block SHALL have ports dout0..dout3, output, 8 each: cached data for port N.
REQ-008 The block SHALL have ports ok0..ok3, output, 1 each: doutN is valid for the current addrN.
REQ-009 The block SHALL have port rom_addr, output, AW: external ROM address, registered.
REQ-010 The block SHALL have port rom_cs, output, 1: external ROM request, registered.
REQ-011 The block SHALL have port rom_data, input, 8: external ROM data.
REQ-012 The block SHALL have port rom_ok, input, 1: rom_data is valid for rom_addr.

Function
REQ-013 Each port SHALL hold one cache entry: valid bit, AW-bit tag, 8-bit data.
REQ-014 okN SHALL be combinational: csN AND validN AND (addrN == tagN); doutN SHALL be dataN, unconditionally.
REQ-015 A port SHALL be pending when csN=1 and okN=0.
REQ-016 The FSM SHALL have two states, IDLE and WAIT.
REQ-017 In IDLE with any port pending, the FSM SHALL grant one port by round-robin, searching from last_grant+1 modulo 4; last_grant resets to 3, so port 0 wins first.
REQ-018 On grant, the FSM SHALL register rom_addr=addrN and rom_cs=1, store the issued address and port index, update last_grant, and enter WAIT.
REQ-019 In WAIT, rom_ok SHALL be ignored for the first SETTLE cycles, then sampled every cycle.
REQ-020 On a sampled rom_ok=1, the block SHALL write the granted entry (tag=issued address, data=rom_data, valid=1), drop rom_cs to 0, and return to IDLE.
REQ-021 Minimum latency with SETTLE=1 and rom_ok held high: new addrN at cycle 0, rom_cs=1 at cycle 1, capture at the end of cycle 2, okN=1 at cycle 3.
REQ-022 The next grant SHALL be issued no earlier than the cycle after capture; peak throughput SHALL be one fetch per 3 cycles.
REQ-023 If addrN or csN changes during WAIT, the fetch SHALL complete against the issued address; the port then re-pends through REQ-014/015 with no abort.
REQ-024 A port whose addrN equals its tag SHALL NOT cause a ROM access; a repeated address is a cache hit.
REQ-025 In IDLE with nothing pending, rom_cs SHALL be 0 and rom_addr SHALL hold its last value.
REQ-026 rom_ok arriving while in IDLE SHALL be ignored.
REQ-027 rom_cs=1 SHALL persist indefinitely while rom_ok=0; there is no timeout.

Reset
REQ-028 While rst=1, the block SHALL set state=IDLE, rom_cs=0, rom_addr=0, all valid=0, tags=0, data=0, last_grant=3; all okN SHALL therefore be 0.
REQ-029 A reset asserted during WAIT SHALL abandon the fetch, and no cache entry SHALL be written.

Structure
REQ-030 A shared package SHALL hold the state enum (IDLE, WAIT) and the port count constant (4).
REQ-031 The round-robin picker SHALL be one sub-module, jt6295_rr: inputs 4-bit pending and 2-bit last, outputs grant index and any-grant flag, purely combinational.

Verification
REQ-032 The bench SHALL cover a single fetch: reset, cs0=1, addr0=0x00100, rom_ok tied 1, rom_data=0x5A -> rom_cs=1 at cycle 1, ok0=1 with dout0=0x5A at cycle 3.
REQ-033 The bench SHALL cover fairness: all four cs=1 with distinct addresses and rom_ok tied 1 -> grants in order 0,1,2,3, all ok=1 by cycle 12.
REQ-034 The bench SHALL cover a hit: after REQ-032, toggle cs0 off then on with the same addr0 -> rom_cs stays 0 and ok0=1 in the cycle cs0 returns.
REQ-035 The bench SHALL cover a stall: rom_ok=0 for 10 cycles after issue -> rom_cs holds 1 and rom_addr is stable; capture occurs one cycle after rom_ok rises.
REQ-036 The bench SHALL cover an address change in flight: addr1 changes 0x10 -> 0x11 during WAIT -> ok1 stays 0, tag1=0x10, a second fetch of 0x11 follows, then ok1=1.
REQ-037 The bench SHALL cover reset mid-fetch: rst pulsed in WAIT with rom_ok=1 -> all ok=0, rom_cs=0 next cycle, no entry written.

Source files
------------

// File: rtl/jt6295_romarb_pkg.sv
// Shared definitions for the JT6295 ROM arbiter.
//   NPORTS  : number of requester ports sharing the external ROM
//   state_t : arbiter FSM states (IDLE, WAIT)
package jt6295_romarb_pkg;

  localparam int NPORTS = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/jt6295_rr.sv
// Round-robin picker for the ROM arbiter. Purely combinational.
//   pending : one bit per port that needs a ROM fetch
//   last    : index of the port granted most recently
//   grant   : first pending port found searching from last+1 (mod 4)
//   any     : at least one port is pending; grant is meaningful only then
module jt6295_rr
  import jt6295_romarb_pkg::*;
(
  input  logic [NPORTS-1:0] pending,
  input  logic [1:0]        last,
  output logic [1:0]        grant,
  output logic              any
);

  // NOTE: every output gets a default before the search so no path leaves
  // a value unassigned, which would otherwise infer a latch.
  always_comb begin
    grant = last;
    any   = 1'b0;
    // i runs 1..4 so the port just served is considered last.
    for (int i = 1; i <= NPORTS; i++) begin
      if (!any && pending[2'(int'(last) + i)]) begin
        grant = 2'(int'(last) + i);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jt6295_romarb.sv
// Four-port ROM arbiter with a one-byte cache per port.
// Each port holds one entry (valid, tag, data). A port whose address misses
// its entry is fetched from the shared ROM, one fetch at a time, ports
// served round-robin.
//   clk, rst           : clock, synchronous active-high reset
//   addr0..3, cs0..3   : requester byte address and request strobe
//   dout0..3, ok0..3   : cached byte and hit flag per port (combinational ok)
//   rom_addr, rom_cs   : registered external ROM request
//   rom_data, rom_ok   : external ROM response
// Parameters: AW = ROM address width, SETTLE = cycles rom_ok is ignored
// after an address is issued.
module jt6295_romarb
  import jt6295_romarb_pkg::*;
#(
  parameter int AW     = 18,
  parameter int SETTLE = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic [AW-1:0] addr3,
  input  logic          cs0,
  input  logic          cs1,
  input  logic          cs2,
  input  logic          cs3,
  output logic [7:0]    dout0,
  output logic [7:0]    dout1,
  output logic [7:0]    dout2,
  output logic [7:0]    dout3,
  output logic          ok0,
  output logic          ok1,
  output logic          ok2,
  output logic          ok3,
  output logic [AW-1:0] rom_addr,
  output logic          rom_cs,
  input  logic [7:0]    rom_data,
  input  logic          rom_ok
);

  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  // Port-indexed views of the flat ports.
  logic [AW-1:0]     addr_a [NPORTS];
  logic [NPORTS-1:0] cs_a;
  logic [NPORTS-1:0] ok_a;
  logic [NPORTS-1:0] pending;

  assign addr_a[0] = addr0;
  assign addr_a[1] = addr1;
  assign addr_a[2] = addr2;
  assign addr_a[3] = addr3;
  assign cs_a      = {cs3, cs2, cs1, cs0};

  // FSM and request registers. rom_addr_q doubles as the issued address
  // used as the tag on capture, so a port changing addrN mid-fetch cannot
  // corrupt the entry being filled.
  state_t          state_q, state_d;
  logic [1:0]      last_q, last_d;
  logic [1:0]      port_q, port_d;
  logic [CW-1:0]   settle_q, settle_d;
  logic [AW-1:0]   rom_addr_q, rom_addr_d;
  logic            rom_cs_q, rom_cs_d;

  // Cache entries, one per port.
  logic [NPORTS-1:0] valid_q, valid_d;
  logic [AW-1:0]     tag_q  [NPORTS];
  logic [AW-1:0]     tag_d  [NPORTS];
  logic [7:0]        data_q [NPORTS];
  logic [7:0]        data_d [NPORTS];

  logic [1:0] rr_grant;
  logic       rr_any;

  always_comb begin
    for (int n = 0; n < NPORTS; n++) begin
      ok_a[n] = cs_a[n] & valid_q[n] & (addr_a[n] == tag_q[n]);
    end
    pending = cs_a & ~ok_a;
  end

  jt6295_rr u_rr (
    .pending (pending),
    .last    (last_q),
    .grant   (rr_grant),
    .any     (rr_any)
  );

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    port_d     = port_q;
    settle_d   = settle_q;
    rom_addr_d = rom_addr_q;
    rom_cs_d   = rom_cs_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    data_d     = data_q;

    case (state_q)
      IDLE: begin
        // rom_ok is deliberately not looked at here; rom_addr keeps its
        // last value when nothing is pending.
        rom_cs_d = 1'b0;
        if (rr_any) begin
          rom_addr_d = addr_a[rr_grant];
          rom_cs_d   = 1'b1;
          port_d     = rr_grant;
          last_d     = rr_grant;
          settle_d   = CW'(SETTLE);
          state_d    = WAIT;
        end
      end
      WAIT: begin
        // No timeout: rom_cs stays high until the ROM answers.
        if (settle_q != '0) begin
          settle_d = settle_q - CW'(1);
        end else if (rom_ok) begin
          valid_d[port_q] = 1'b1;
          tag_d[port_q]   = rom_addr_q;
          data_d[port_q]  = rom_data;
          rom_cs_d        = 1'b0;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 2'd3;
      port_q     <= 2'd0;
      settle_q   <= '0;
      rom_addr_q <= '0;
      rom_cs_q   <= 1'b0;
      valid_q    <= '0;
      // NOTE: the cache is only four entries and its tags/data are
      // observable on dout, so it is cleared on reset like any other flop.
      for (int n = 0; n < NPORTS; n++) begin
        tag_q[n]  <= '0;
        data_q[n] <= '0;
      end
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      port_q     <= port_d;
      settle_q   <= settle_d;
      rom_addr_q <= rom_addr_d;
      rom_cs_q   <= rom_cs_d;
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign rom_cs   = rom_cs_q;

  assign ok0   = ok_a[0];
  assign ok1   = ok_a[1];
  assign ok2   = ok_a[2];
  assign ok3   = ok_a[3];
  assign dout0 = data_q[0];
  assign dout1 = data_q[1];
  assign dout2 = data_q[2];
  assign dout3 = data_q[3];

endmodule

// File: tb/tb_jt6295_romarb.sv
// Directed bench for jt6295_romarb (AW=18, SETTLE=1).
// Cycle k starts 1 time unit after the k-th rising edge; inputs are driven
// there and outputs are checked 1 unit later, well before the next edge.
// The ROM model returns 0x5A when rom_fixed is set, otherwise the low
// address byte XOR 0x3C.
module tb_jt6295_romarb;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] addr0, addr1, addr2, addr3;
  logic        cs0, cs1, cs2, cs3;
  logic [7:0]  dout0, dout1, dout2, dout3;
  logic        ok0, ok1, ok2, ok3;
  logic [17:0] rom_addr;
  logic        rom_cs;
  logic [7:0]  rom_data;
  logic        rom_ok;
  logic        rom_fixed;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign rom_data = rom_fixed ? 8'h5A : (rom_addr[7:0] ^ 8'h3C);

  jt6295_romarb #(.AW(18), .SETTLE(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr0    (addr0),
    .addr1    (addr1),
    .addr2    (addr2),
    .addr3    (addr3),
    .cs0      (cs0),
    .cs1      (cs1),
    .cs2      (cs2),
    .cs3      (cs3),
    .dout0    (dout0),
    .dout1    (dout1),
    .dout2    (dout2),
    .dout3    (dout3),
    .ok0      (ok0),
    .ok1      (ok1),
    .ok2      (ok2),
    .ok3      (ok3),
    .rom_addr (rom_addr),
    .rom_cs   (rom_cs),
    .rom_data (rom_data),
    .rom_ok   (rom_ok)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at the start of a fresh cycle with reset released.
  task automatic do_reset();
    rst    = 1'b1;
    cs0 = 1'b0; cs1 = 1'b0; cs2 = 1'b0; cs3 = 1'b0;
    addr0 = '0; addr1 = '0; addr2 = '0; addr3 = '0;
    rom_ok = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic        prev_cs;
  int          n_iss;
  logic [17:0] iss_addr [4];
  int          iss_cyc  [4];

  initial begin
    rom_fixed = 1'b1;
    do_reset();

    // Reset state
    #1;
    check("rst_rom_cs", rom_cs, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_ok", {ok3, ok2, ok1, ok0}, 0);
    check("rst_dout0", dout0, 0);

    // Single fetch: addr at cycle 0, rom_cs at 1, ok at 3
    cs0 = 1'b1; addr0 = 18'h00100;
    #1;
    check("single_c0_rom_cs", rom_cs, 0);
    check("single_c0_ok0", ok0, 0);
    tick();
    check("single_c1_rom_cs", rom_cs, 1);
    check("single_c1_rom_addr", rom_addr, 18'h00100);
    tick();
    check("single_c2_ok0", ok0, 0);
    check("single_c2_rom_cs", rom_cs, 1);
    tick();
    check("single_c3_ok0", ok0, 1);
    check("single_c3_dout0", dout0, 8'h5A);
    check("single_c3_rom_cs", rom_cs, 0);

    // Hit: cs0 off then back on with the same address
    tick();
    cs0 = 1'b0;
    #1;
    check("hit_off_ok0", ok0, 0);
    tick();
    check("hit_off_rom_cs", rom_cs, 0);
    cs0 = 1'b1;
    #1;
    check("hit_on_ok0", ok0, 1);
    check("hit_on_rom_cs", rom_cs, 0);
    tick();
    check("hit_after_rom_cs", rom_cs, 0);
    check("hit_after_ok0", ok0, 1);

    // Fairness: four requesters at once, issues at cycles 1,4,7,10
    rom_fixed = 1'b0;
    do_reset();
    cs0 = 1'b1; cs1 = 1'b1; cs2 = 1'b1; cs3 = 1'b1;
    addr0 = 18'h00200; addr1 = 18'h00201; addr2 = 18'h00202; addr3 = 18'h00203;
    #1;
    prev_cs = rom_cs;
    n_iss   = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      tick();
      if (rom_cs && !prev_cs) begin
        if (n_iss < 4) begin
          iss_addr[n_iss] = rom_addr;
          iss_cyc[n_iss]  = cyc;
        end
        n_iss++;
      end
      prev_cs = rom_cs;
      if (cyc == 11) check("fair_c11_ok3", ok3, 0);
    end
    check("fair_issue_count", n_iss, 4);
    for (int i = 0; i < 4 && i < n_iss; i++) begin
      check($sformatf("fair_order%0d", i), iss_addr[i], 18'h00200 + 18'(i));
      check($sformatf("fair_cycle%0d", i), iss_cyc[i], 1 + 3 * i);
    end
    check("fair_c12_ok", {ok3, ok2, ok1, ok0}, 4'hF);
    check("fair_dout0", dout0, 8'h3C);
    check("fair_dout1", dout1, 8'h3D);
    check("fair_dout2", dout2, 8'h3E);
    check("fair_dout3", dout3, 8'h3F);

    // Stall: rom_ok low for 10 cycles after issue
    do_reset();
    rom_ok = 1'b0;
    cs2 = 1'b1; addr2 = 18'h2AAAA;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      tick();
      check($sformatf("stall_c%0d_rom_cs", cyc), rom_cs, 1);
      check($sformatf("stall_c%0d_rom_addr", cyc), rom_addr, 18'h2AAAA);
      check($sformatf("stall_c%0d_ok2", cyc), ok2, 0);
    end
    tick();
    rom_ok = 1'b1;
    #1;
    check("stall_c11_ok2", ok2, 0);
    check("stall_c11_rom_cs", rom_cs, 1);
    tick();
    check("stall_c12_ok2", ok2, 1);
    check("stall_c12_rom_cs", rom_cs, 0);
    check("stall_c12_dout2", dout2, 8'h96);

    // Address change in flight: 0x10 issued, addr1 moves to 0x11 during WAIT
    do_reset();
    cs1 = 1'b1; addr1 = 18'h00010;
    tick();
    check("chg_c1_rom_addr", rom_addr, 18'h00010);
    addr1 = 18'h00011;
    #1;
    check("chg_c1_ok1", ok1, 0);
    tick();
    check("chg_c2_ok1", ok1, 0);
    tick();
    check("chg_c3_ok1", ok1, 0);
    check("chg_c3_dout1", dout1, 8'h2C);
    check("chg_c3_rom_cs", rom_cs, 0);
    tick();
    check("chg_c4_rom_cs", rom_cs, 1);
    check("chg_c4_rom_addr", rom_addr, 18'h00011);
    tick();
    check("chg_c5_ok1", ok1, 0);
    tick();
    check("chg_c6_ok1", ok1, 1);
    check("chg_c6_dout1", dout1, 8'h2D);

    // Reset during the sampling cycle of WAIT with rom_ok high
    do_reset();
    cs0 = 1'b1; addr0 = 18'h00055;
    tick();
    check("rstw_c1_rom_cs", rom_cs, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rstw_c3_rom_cs", rom_cs, 0);
    check("rstw_c3_rom_addr", rom_addr, 0);
    check("rstw_c3_ok", {ok3, ok2, ok1, ok0}, 0);
    check("rstw_c3_dout0", dout0, 0);
    tick();
    check("rstw_c4_rom_cs", rom_cs, 1);
    tick();
    tick();
    check("rstw_c6_ok0", ok0, 1);
    check("rstw_c6_dout0", dout0, 8'h69);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
